pwm_capture_8ch: RTL and testbench
==================================

PWM_CAPTURE_8CH -- requirements
Module: pwm_capture_8ch

Interface
REQ-001 Parameter NUM_CH, default 8, is the number of PWM input channels.
REQ-002 Parameter CNT_W, default 24, is the width of each pulse-width counter in ACLK cycles.
REQ-003 Parameter TIMEOUT_CYC, default 5_000_000 (50 ms at 100 MHz), is the idle cycles after which a channel is declared lost.
REQ-004 Port ACLK, input, 1: single clock; all state SHALL be clocked on its rising edge.
REQ-005 Port ARESETN, input, 1: asynchronous active-low reset.
REQ-006 Port enable, input, 1: capture enable; low holds every channel idle.
REQ-007 Port pwm_in, input, NUM_CH: asynchronous PWM pins, one bit per channel.
REQ-008 Port pulse_width, output, NUM_CH*CNT_W: last measured high time per channel; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-009 Port sample_stb, output, NUM_CH: one-cycle pulse per channel when pulse_width is updated.
REQ-010 Port ch_valid, output, NUM_CH: channel has a fresh measurement and has not timed out.
REQ-011 Port ch_timeout, output, NUM_CH: sticky loss-of-signal flag per channel.

Function
REQ-012 Each pwm_in bit SHALL pass through a 2-FF synchronizer; a third register holds the previous synchronized level for edge detection.
REQ-013 rise = sync & ~prev; fall = ~sync & prev; channels operate fully independently, so edges on different channels in the same cycle are all honoured.
REQ-014 On rise, the channel SHALL set armed=1, load hi_cnt=1 and clear idle_cnt.
REQ-015 While sync is high and not rise, hi_cnt SHALL increment by 1 and saturate at 2^CNT_W-1, never wrapping.
REQ-016 On fall with armed=1, pulse_width[k] SHALL load hi_cnt, so a pin high for exactly N cycles reports N (N < 2^CNT_W).
REQ-017 sample_stb[k] SHALL assert in the cycle after that load, for exactly one cycle; total latency from pin falling edge to sample_stb is 4 ACLK cycles.
REQ-018 On that load, ch_valid[k] SHALL be set to 1 and ch_timeout[k] cleared.
REQ-019 A fall with armed=0 (pin already high at reset release or at enable rising) SHALL be ignored: no update, no strobe.
REQ-020 idle_cnt SHALL increment every enabled cycle without a rise and saturate at TIMEOUT_CYC.
REQ-021 When idle_cnt reaches TIMEOUT_CYC, ch_valid[k] SHALL be set to 0 and ch_timeout[k] set to 1; pulse_width[k] is retained.
REQ-022 If rise and the timeout threshold occur in the same cycle, rise SHALL win and no timeout is flagged.
REQ-023 While enable=0, armed, hi_cnt and idle_cnt SHALL be held at 0, ch_valid SHALL be 0, sample_stb SHALL be 0; pulse_width and ch_timeout are retained.

Reset
REQ-024 ARESETN low SHALL asynchronously clear synchronizers, armed, hi_cnt, idle_cnt, pulse_width, sample_stb, ch_valid and ch_timeout to 0.
REQ-025 Reset asserted mid-pulse SHALL discard the pulse in progress; the next reported sample needs a fresh rise after reset release.

Structure
REQ-026 A shared package pwm_reader_pkg SHALL hold NUM_CH, CNT_W, TIMEOUT_CYC defaults and the channel-width typedef, for reuse by the AXI register file that reads these outputs.
REQ-027 Per-channel logic SHALL be a sub-module pwm_capture_ch instantiated NUM_CH times by a generate loop; the top level only concatenates outputs.

Verification (ACLK 100 MHz; bench overrides TIMEOUT_CYC=1000)
REQ-028 ch0 high 150 cycles, enable=1 -> pulse_width[0]=150, sample_stb[0] one cycle 4 cycles after the falling edge, ch_valid[0]=1; other channels unchanged.
REQ-029 All 8 channels pulsed at once with widths 100,200,...,800 -> each pulse_width[k]=100*(k+1), each strobe exactly once.
REQ-030 ch3 idle for 1000 cycles after a valid sample -> ch_valid[3]=0, ch_timeout[3]=1, pulse_width[3] unchanged; next 120-cycle pulse -> width 120, ch_valid=1, ch_timeout=0.
REQ-031 CNT_W=8 build, ch1 high 300 cycles -> pulse_width[1]=255, no wrap.
REQ-032 ARESETN pulsed low while ch2 is high, released while still high, then pin falls -> no sample_stb[2], pulse_width[2]=0; following 50-cycle pulse -> width 50.
REQ-033 enable=0 during a 100-cycle pulse on ch4 -> no strobe, ch_valid[4]=0, width retained; re-enable mid-high, fall -> ignored.

Source files
------------

// File: rtl/pwm_reader_pkg.sv
// Shared defaults for the PWM capture block and the register file that
// reads its outputs.
//   NUM_CH_DEF      : number of PWM input channels
//   CNT_W_DEF       : pulse-width counter width, in ACLK cycles
//   TIMEOUT_CYC_DEF : idle cycles before a channel is declared lost
//   ch_width_t      : one channel's pulse-width value at the default width
package pwm_reader_pkg;

    localparam int NUM_CH_DEF      = 8;
    localparam int CNT_W_DEF       = 24;
    localparam int TIMEOUT_CYC_DEF = 5_000_000;

    typedef logic [CNT_W_DEF-1:0] ch_width_t;

endpackage

// File: rtl/pwm_capture_8ch_if.sv
// Signal bundle between the PWM capture block and its user.
//   enable      : capture enable (low holds all channels idle)
//   pwm_in      : asynchronous PWM pins, one bit per channel
//   pulse_width : last measured high time, channel k at [k*CNT_W +: CNT_W]
//   sample_stb  : one-cycle pulse per channel when pulse_width updates
//   ch_valid    : channel holds a fresh, non-timed-out measurement
//   ch_timeout  : sticky loss-of-signal flag per channel
// master = the side driving enable/pins, slave = the capture block.
interface pwm_capture_8ch_if
    import pwm_reader_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                    enable;
    logic [NUM_CH-1:0]       pwm_in;
    logic [NUM_CH*CNT_W-1:0] pulse_width;
    logic [NUM_CH-1:0]       sample_stb;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_timeout;

    modport master (
        output enable, pwm_in,
        input  pulse_width, sample_stb, ch_valid, ch_timeout
    );

    modport slave (
        input  enable, pwm_in,
        output pulse_width, sample_stb, ch_valid, ch_timeout
    );
endinterface

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchronizes the pin, times each high phase and
// reports it after the falling edge, and flags loss of signal when no
// rising edge arrives within TIMEOUT_CYC cycles.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   enable        : capture enable
//   pwm_in        : asynchronous pin
//   pulse_width   : last measured high time (saturating)
//   sample_stb    : one-cycle strobe, the cycle after pulse_width loads
//   ch_valid      : fresh measurement, not timed out
//   ch_timeout    : sticky loss-of-signal flag
module pwm_capture_ch
    import pwm_reader_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] pulse_width,
    output logic             sample_stb,
    output logic             ch_valid,
    output logic             ch_timeout
);
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  HI_MAX    = '1;
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic              meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic [1:0]        warm_q, warm_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d, width_q, width_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              upd_q, upd_d, stb_q, stb_d;
    logic              valid_q, valid_d, tout_q, tout_d;
    logic              rise, fall;

    // After reset the synchronizer and prev flops hold zeros that were never
    // sampled from the pin. warm_q counts the first three edges so a pin that
    // is already high at reset release is not mistaken for a rising edge.
    assign rise = sync_q & ~prev_q & (warm_q == 2'd3);
    assign fall = ~sync_q & prev_q;

    always_comb begin
        meta_d     = pwm_in;
        sync_d     = meta_q;
        prev_d     = sync_q;
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        armed_d    = armed_q;
        hi_cnt_d   = hi_cnt_q;
        idle_cnt_d = idle_cnt_q;
        width_d    = width_q;
        upd_d      = 1'b0;
        stb_d      = upd_q;
        valid_d    = valid_q;
        tout_d     = tout_q;

        if (!enable) begin
            armed_d    = 1'b0;
            hi_cnt_d   = '0;
            idle_cnt_d = '0;
            valid_d    = 1'b0;
            stb_d      = 1'b0;
        end else begin
            if (rise) begin
                armed_d    = 1'b1;
                hi_cnt_d   = CNT_W'(1);
                idle_cnt_d = '0;
            end else begin
                if (sync_q && hi_cnt_q != HI_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
                if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
                // Flag only on the step into the threshold; a rise in the
                // same cycle takes the branch above and suppresses it.
                if (idle_cnt_q == IDLE_LAST) begin
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                end
            end
            if (fall && armed_q) begin
                width_d = hi_cnt_q;
                upd_d   = 1'b1;
                valid_d = 1'b1;
                tout_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            prev_q     <= 1'b0;
            warm_q     <= 2'd0;
            armed_q    <= 1'b0;
            hi_cnt_q   <= '0;
            idle_cnt_q <= '0;
            width_q    <= '0;
            upd_q      <= 1'b0;
            stb_q      <= 1'b0;
            valid_q    <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
            hi_cnt_q   <= hi_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            width_q    <= width_d;
            upd_q      <= upd_d;
            stb_q      <= stb_d;
            valid_q    <= valid_d;
            tout_q     <= tout_d;
        end
    end

    assign pulse_width = width_q;
    assign sample_stb  = stb_q;
    assign ch_valid    = valid_q;
    assign ch_timeout  = tout_q;
endmodule

// File: rtl/pwm_capture_8ch.sv
// Multi-channel PWM pulse-width capture. Each channel is an independent
// pwm_capture_ch; this level only fans the interface out and back in.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   bus (slave)   : enable, pwm_in in; pulse_width, sample_stb, ch_valid,
//                   ch_timeout out
module pwm_capture_8ch
    import pwm_reader_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    pwm_capture_8ch_if.slave bus
);
    logic [NUM_CH*CNT_W-1:0] pw_all;
    logic [NUM_CH-1:0]       stb_all, valid_all, tout_all;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_capture_ch #(
            .CNT_W      (CNT_W),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_ch (
            .ACLK       (ACLK),
            .ARESETN    (ARESETN),
            .enable     (bus.enable),
            .pwm_in     (bus.pwm_in[k]),
            .pulse_width(pw_all[k*CNT_W +: CNT_W]),
            .sample_stb (stb_all[k]),
            .ch_valid   (valid_all[k]),
            .ch_timeout (tout_all[k])
        );
    end

    assign bus.pulse_width = pw_all;
    assign bus.sample_stb  = stb_all;
    assign bus.ch_valid    = valid_all;
    assign bus.ch_timeout  = tout_all;
endmodule

// File: tb/tb_pwm_capture_8ch.sv
module tb_pwm_capture_8ch;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pwm = 8'h00;
    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwm_capture_8ch_if #(.NUM_CH(8), .CNT_W(24)) ifw ();
    pwm_capture_8ch_if #(.NUM_CH(8), .CNT_W(8))  ifn ();
    assign ifw.enable = enable;
    assign ifw.pwm_in = pwm;
    assign ifn.enable = enable;
    assign ifn.pwm_in = pwm;

    pwm_capture_8ch #(.NUM_CH(8), .CNT_W(24), .TIMEOUT_CYC(1000)) dut_w (
        .ACLK(clk), .ARESETN(rstn), .bus(ifw));
    pwm_capture_8ch #(.NUM_CH(8), .CNT_W(8), .TIMEOUT_CYC(1000)) dut_n (
        .ACLK(clk), .ARESETN(rstn), .bus(ifn));

    logic [23:0] pw_w[8];
    logic [7:0]  pw_n[8];
    for (genvar g = 0; g < 8; g++) begin : g_sl
        assign pw_w[g] = ifw.pulse_width[g*24 +: 24];
        assign pw_n[g] = ifn.pulse_width[g*8 +: 8];
    end

    typedef struct { int ch; int width; longint due; } exp_t;
    typedef struct { int ch; int width; int exp_w; int exp_n; } vec_t;
    exp_t sb_w[$];
    exp_t sb_n[$];
    int   exp_w[8];
    int   exp_n[8];
    vec_t vecs[6];

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_model(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s pw_w[%0d]", tag, k), longint'(pw_w[k]), longint'(exp_w[k]));
            chk($sformatf("%s pw_n[%0d]", tag, k), longint'(pw_n[k]), longint'(exp_n[k]));
        end
    endtask

    function automatic int sat8(input int w);
        return (w > 255) ? 255 : w;
    endfunction

    task automatic mon();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                if (ifw.sample_stb[k]) begin
                    if (sb_w.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stb_w_unexpected ch%0d actual=1 required=0 (cyc %0d)", k, cyc);
                    end else begin
                        e = sb_w.pop_front();
                        chk("stb_w_ch", k, e.ch);
                        chk("stb_w_width", longint'(pw_w[k]), e.width);
                        chk("stb_w_latency", cyc, e.due);
                        chk("stb_w_valid", longint'(ifw.ch_valid[k]), 1);
                    end
                end
                if (ifn.sample_stb[k]) begin
                    if (sb_n.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stb_n_unexpected ch%0d actual=1 required=0 (cyc %0d)", k, cyc);
                    end else begin
                        e = sb_n.pop_front();
                        chk("stb_n_ch", k, e.ch);
                        chk("stb_n_width", longint'(pw_n[k]), e.width);
                        chk("stb_n_latency", cyc, e.due);
                    end
                end
            end
        end
    endtask

    task automatic drive_pulses(input logic [7:0] mask, input int w[8],
                                input int ew[8], input int en[8]);
        int maxw;
        maxw = 0;
        for (int k = 0; k < 8; k++)
            if (mask[k] && w[k] > maxw) maxw = w[k];
        @(posedge clk); #1;
        pwm = pwm | mask;
        for (int t = 1; t <= maxw; t++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                if (mask[k] && w[k] == t) begin
                    pwm[k] = 1'b0;
                    sb_w.push_back('{k, ew[k], cyc + 4});
                    sb_n.push_back('{k, en[k], cyc + 4});
                    exp_w[k] = ew[k];
                    exp_n[k] = en[k];
                end
            end
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic single(input int ch, input int w);
        int wa[8];
        int ea[8];
        int na[8];
        for (int k = 0; k < 8; k++) begin wa[k] = 0; ea[k] = 0; na[k] = 0; end
        wa[ch] = w; ea[ch] = w; na[ch] = sat8(w);
        drive_pulses(8'(1 << ch), wa, ea, na);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wa[8];
        int ea[8];
        int na[8];
        vecs[0] = '{0, 150, 150, 150};
        vecs[1] = '{5, 37, 37, 37};
        vecs[2] = '{7, 1, 1, 1};
        vecs[3] = '{6, 2, 2, 2};
        vecs[4] = '{1, 300, 300, 255};
        vecs[5] = '{2, 64, 64, 64};
        for (int k = 0; k < 8; k++) begin exp_w[k] = 0; exp_n[k] = 0; end

        fork
            mon();
        join_none

        cycles(5);
        rstn = 1'b1;
        cycles(3);
        chk("rst ch_valid", longint'(ifw.ch_valid), 0);
        chk("rst ch_timeout", longint'(ifw.ch_timeout), 0);
        chk("rst sample_stb", longint'(ifw.sample_stb), 0);
        chk_model("rst");
        enable = 1'b1;
        cycles(5);

        // single-channel vectors from the table
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 8; k++) begin wa[k] = 0; ea[k] = 0; na[k] = 0; end
            wa[vecs[v].ch] = vecs[v].width;
            ea[vecs[v].ch] = vecs[v].exp_w;
            na[vecs[v].ch] = vecs[v].exp_n;
            drive_pulses(8'(1 << vecs[v].ch), wa, ea, na);
            chk($sformatf("vec%0d valid", v), longint'(ifw.ch_valid[vecs[v].ch]), 1);
            chk_model($sformatf("vec%0d", v));
        end

        // all eight channels at once, widths 100..800
        for (int k = 0; k < 8; k++) begin
            wa[k] = 100 * (k + 1); ea[k] = wa[k]; na[k] = sat8(wa[k]);
        end
        drive_pulses(8'hFF, wa, ea, na);
        chk_model("all8");
        chk("all8 valid", longint'(ifw.ch_valid), 255);
        chk("all8 timeout", longint'(ifw.ch_timeout), 0);

        // loss of signal on ch3, then recovery
        cycles(1100);
        chk("tout valid3", longint'(ifw.ch_valid[3]), 0);
        chk("tout flag3", longint'(ifw.ch_timeout[3]), 1);
        chk_model("tout");
        single(3, 120);
        chk("recover valid3", longint'(ifw.ch_valid[3]), 1);
        chk("recover flag3", longint'(ifw.ch_timeout[3]), 0);
        chk_model("recover");

        // reset while ch2 is high: that pulse is discarded
        pwm[2] = 1'b1;
        cycles(20);
        rstn = 1'b0;
        cycles(3);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin exp_w[k] = 0; exp_n[k] = 0; end
        cycles(20);
        pwm[2] = 1'b0;
        cycles(12);
        chk("midrst valid", longint'(ifw.ch_valid), 0);
        chk("midrst timeout", longint'(ifw.ch_timeout), 0);
        chk_model("midrst");
        single(2, 50);
        chk_model("post_rst");

        // enable dropped mid-pulse on ch4, then re-enabled mid-high
        single(4, 77);
        pwm[4] = 1'b1;
        cycles(30);
        enable = 1'b0;
        cycles(70);
        pwm[4] = 1'b0;
        cycles(10);
        chk("dis valid", longint'(ifw.ch_valid), 0);
        chk("dis stb", longint'(ifw.sample_stb), 0);
        chk_model("dis");
        pwm[4] = 1'b1;
        cycles(20);
        enable = 1'b1;
        cycles(30);
        pwm[4] = 1'b0;
        cycles(10);
        chk("reen valid4", longint'(ifw.ch_valid[4]), 0);
        chk_model("reen");
        single(4, 40);
        chk("final valid4", longint'(ifw.ch_valid[4]), 1);
        chk_model("final");

        cycles(5);
        chk("sb_w drained", sb_w.size(), 0);
        chk("sb_n drained", sb_n.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
